// File: rtl/poly_piano_pkg.sv
// Shared constants and helpers for the polyphonic piano core: note divisors, octave saturation
// and index/mix width helpers.
package poly_piano_pkg;

  localparam int NOTES = 12;

  // Octave-3 half-period divisors at 10 MHz, C3 first
  localparam logic [15:0] NOTE_DIV [NOTES] = '{
    16'd38223, 16'd36077, 16'd34052, 16'd32141, 16'd30337, 16'd28635,
    16'd27027, 16'd25510, 16'd24079, 16'd22727, 16'd21452, 16'd20248
  };

  function automatic logic [2:0] sat7(input logic [3:0] v);
    return (v > 4'd7) ? 3'd7 : v[2:0];
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int mix_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/piano_voice.sv
// One square-wave voice: half-period counter with a latched divisor.
// load re-initialises with a new divisor; clr holds the voice silent.
module piano_voice #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             wave
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      cnt   <= '0;
      wave  <= 1'b0;
    end else if (load) begin
      div_q <= div;
      cnt   <= '0;
      wave  <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      wave  <= 1'b0;
    end else if (cnt == div_q - DIV_W'(1)) begin
      cnt   <= '0;
      wave  <= ~wave;
    end else begin
      cnt   <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/poly_piano_core.sv
// Polyphonic piano core: rotating key scan allocates voices, voices are mixed into 1-bit PWM.
// Optional build macro VOICE_STEAL_EN: a new press with no free voice steals one round-robin.
module poly_piano_core
  import poly_piano_pkg::*;
#(
  parameter int NUM_KEYS   = 12,
  parameter int NUM_VOICES = 4,
  parameter int DIV_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [NUM_KEYS-1:0]   keys,
  input  logic [2:0]            octave,
  output logic                  audio_out,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  all_busy,
  output logic                  dropped
);

  localparam int SW = idx_w(NUM_KEYS);
  localparam int VW = idx_w(NUM_VOICES);
  localparam int MW = mix_w(NUM_VOICES);

  logic [NUM_KEYS-1:0]   key_q, key_prev, req, req_nx;
  logic [SW-1:0]         scan_idx;
  logic [SW-1:0]         voice_key [NUM_VOICES];
  logic [NUM_VOICES-1:0] wave, load_v, clr_v, act_nx;
  logic [MW-1:0]         pwm_cnt, mix;

  logic          key_bit, req_eff, hit, have_free, rel, alloc, steal, drop, load_any;
  logic [VW-1:0] hit_v, free_v, tgt;
  logic [3:0]    oct_sum;
  logic [2:0]    new_oct;
  logic [15:0]   base, shifted;
  logic [DIV_W-1:0] new_div;
  int            k_i;

`ifdef VOICE_STEAL_EN
  logic [VW-1:0] steal_ptr;
`endif

  always_comb begin
    k_i     = int'(scan_idx);
    key_bit = key_q[scan_idx];
    req_eff = req[scan_idx] | (key_q[scan_idx] & ~key_prev[scan_idx]);

    hit   = 1'b0;
    hit_v = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      if (voice_active[v] && voice_key[v] == scan_idx) begin
        hit   = 1'b1;
        hit_v = VW'(v);
      end

    have_free = ~&voice_active;
    free_v    = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--)
      if (!voice_active[v]) free_v = VW'(v);

    rel   = hit & ~key_bit;
    alloc = ~hit & key_bit & have_free;
`ifdef VOICE_STEAL_EN
    steal = ~hit & key_bit & req_eff & ~have_free;
    drop  = 1'b0;
    tgt   = alloc ? free_v : steal_ptr;
`else
    steal = 1'b0;
    drop  = ~hit & req_eff & ~have_free;
    tgt   = free_v;
`endif
    load_any = alloc | steal;

    // Keys 12..23 sit one octave above the table
    oct_sum = {1'b0, octave} + ((k_i >= NOTES) ? 4'd1 : 4'd0);
    new_oct = sat7(oct_sum);
    base    = NOTE_DIV[k_i % NOTES];
    shifted = base >> new_oct;
    new_div = (shifted < 16'd2) ? DIV_W'(2) : DIV_W'(shifted);

    load_v = '0;
    clr_v  = ~voice_active;
    act_nx = voice_active;
    if (rel) begin
      clr_v[hit_v]  = 1'b1;
      act_nx[hit_v] = 1'b0;
    end
    if (load_any) begin
      load_v[tgt] = 1'b1;
      act_nx[tgt] = 1'b1;
    end

    // Every outcome at a key's own slot consumes its pending press
    req_nx = (req | (key_q & ~key_prev)) & key_q;
    req_nx[scan_idx] = 1'b0;

    mix = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      mix = mix + MW'(wave[v] & voice_active[v]);
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    piano_voice #(.DIV_W(DIV_W)) u_voice (
      .clk  (clk),
      .rst  (rst),
      .load (load_v[v]),
      .clr  (clr_v[v]),
      .div  (new_div),
      .wave (wave[v])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q        <= '0;
      key_prev     <= '0;
      req          <= '0;
      scan_idx     <= '0;
      voice_active <= '0;
      all_busy     <= 1'b0;
      dropped      <= 1'b0;
      pwm_cnt      <= '0;
      audio_out    <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) voice_key[v] <= '0;
`ifdef VOICE_STEAL_EN
      steal_ptr    <= '0;
`endif
    end else begin
      key_q        <= keys;
      key_prev     <= key_q;
      req          <= req_nx;
      scan_idx     <= (scan_idx == SW'(NUM_KEYS - 1)) ? '0 : scan_idx + SW'(1);
      voice_active <= act_nx;
      all_busy     <= &act_nx;
      dropped      <= drop;
      if (load_any) voice_key[tgt] <= scan_idx;
      pwm_cnt      <= (pwm_cnt == MW'(NUM_VOICES - 1)) ? '0 : pwm_cnt + MW'(1);
      audio_out    <= ena & (pwm_cnt < mix);
`ifdef VOICE_STEAL_EN
      if (steal) steal_ptr <= (steal_ptr == VW'(NUM_VOICES - 1)) ? '0 : steal_ptr + VW'(1);
`endif
    end
  end

endmodule
